p2_exp_master: RTL and testbench



---
 rtl/p2_exp_pkg.sv | 40 ++++
 rtl/p2_exp_master_if.sv | 27 ++
 rtl/p2_exp_timer.sv | 35 +++
 rtl/p2_exp_master.sv | 150 +++++++++++++++
 tb/tb_p2_exp_master.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/p2_exp_pkg.sv
// Shared types for the P2/PROG nibble expander bus: opcodes, port selects,
// FSM states and the latched command payload.
package p2_exp_pkg;

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned PORT_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_RD  = 2'b00,
    OP_WR  = 2'b01,
    OP_OR  = 2'b10,
    OP_AND = 2'b11
  } op_e;

  localparam logic [PORT_W-1:0] PORT4 = 2'd0;
  localparam logic [PORT_W-1:0] PORT5 = 2'd1;
  localparam logic [PORT_W-1:0] PORT6 = 2'd2;
  localparam logic [PORT_W-1:0] PORT7 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_PLO_A,
    ST_PLO_D,
    ST_HOLD
  } state_e;

  typedef struct packed {
    op_e               op;
    logic [PORT_W-1:0] port;
    logic [NIB_W-1:0]  wdata;
  } cmd_t;

  // Address nibble as it appears on P2: opcode in the upper bits, port below.
  function automatic logic [NIB_W-1:0] addr_nibble(input op_e op, input logic [PORT_W-1:0] port);
    return {op, port};
  endfunction

endpackage

// File: rtl/p2_exp_master_if.sv
// Command/response and P2/PROG bus bundle for the expander initiator.
interface p2_exp_master_if;
  import p2_exp_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [PORT_W-1:0] cmd_port;
  logic [NIB_W-1:0]  cmd_wdata;
  logic              rsp_valid;
  logic [NIB_W-1:0]  rsp_rdata;
  logic [NIB_W-1:0]  p2o;
  logic              p2_oe;
  logic [NIB_W-1:0]  p2i;
  logic              prog_n;

  modport master (
    input  cmd_valid, cmd_op, cmd_port, cmd_wdata, p2i,
    output cmd_ready, rsp_valid, rsp_rdata, p2o, p2_oe, prog_n
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_port, cmd_wdata, p2i,
    input  cmd_ready, rsp_valid, rsp_rdata, p2o, p2_oe, prog_n
  );

endinterface

// File: rtl/p2_exp_timer.sv
// Loadable down-counter that parks at zero; zero flag drives phase advance.
module p2_exp_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_c_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign zero_c_o = (cnt_q == '0);

endmodule

// File: rtl/p2_exp_master.sv
// Initiator for the 8243-style expander: turns one command into a PROG-framed
// address nibble followed by a data nibble on P2, then pulses rsp_valid.
module p2_exp_master
  import p2_exp_pkg::*;
#(
  parameter int unsigned T_AS  = 2,
  parameter int unsigned T_AH  = 2,
  parameter int unsigned T_PW  = 6,
  parameter int unsigned T_DH  = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  p2_exp_master_if.master     bus
);

  localparam int unsigned T_MAX = (32'd1 << CNT_W) - 32'd1;

  if (T_AS == 0 || T_AH == 0 || T_PW < 2 || T_DH == 0) begin : g_bad_timing
    $error("p2_exp_master: T_AS/T_AH/T_DH must be >= 1 and T_PW >= 2");
  end
  if (T_AS > T_MAX || T_AH > T_MAX || T_PW > T_MAX || T_DH > T_MAX) begin : g_bad_width
    $error("p2_exp_master: timing parameter does not fit in CNT_W bits");
  end

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic              prog_n_q, prog_n_d;
  logic              p2_oe_q, p2_oe_d;
  logic [NIB_W-1:0]  p2o_q, p2o_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [NIB_W-1:0]  rdata_q, rdata_d;

  logic              timer_load;
  logic [CNT_W-1:0]  timer_val;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_zero;

  function automatic logic [CNT_W-1:0] phase_len(input state_e s);
    case (s)
      ST_ADDR:  return CNT_W'(T_AS - 1);
      ST_PLO_A: return CNT_W'(T_AH - 1);
      ST_PLO_D: return CNT_W'(T_PW - 1);
      ST_HOLD:  return CNT_W'(T_DH - 1);
      default:  return '0;
    endcase
  endfunction

  p2_exp_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .cnt_o      (cnt),
    .zero_c_o   (cnt_zero)
  );

  // Next state plus next values of the registered bus outputs (decoded from state_d).
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    timer_load  = 1'b0;
    timer_val   = '0;
    prog_n_d    = 1'b1;
    p2_oe_d     = 1'b0;
    p2o_d       = p2o_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          state_d     = ST_ADDR;
          cmd_d.op    = op_e'(bus.cmd_op);
          cmd_d.port  = bus.cmd_port;
          cmd_d.wdata = bus.cmd_wdata;
        end
      end
      ST_ADDR:  if (cnt_zero) state_d = ST_PLO_A;
      ST_PLO_A: if (cnt_zero) state_d = ST_PLO_D;
      ST_PLO_D: if (cnt_zero) state_d = ST_HOLD;
      ST_HOLD:  if (cnt_zero) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      timer_load = 1'b1;
      timer_val  = phase_len(state_d);
    end

    // p2o only moves on edges where prog_n holds its level.
    case (state_d)
      ST_ADDR, ST_PLO_A: begin
        p2o_d    = addr_nibble(cmd_d.op, cmd_d.port);
        p2_oe_d  = 1'b1;
        prog_n_d = (state_d == ST_ADDR);
      end
      ST_PLO_D: begin
        prog_n_d = 1'b0;
        if (cmd_d.op != OP_RD) begin
          p2o_d   = cmd_d.wdata;
          p2_oe_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cmd_d.op != OP_RD) begin
          p2o_d   = cmd_d.wdata;
          p2_oe_d = 1'b1;
        end
        rsp_valid_d = timer_load ? (T_DH == 1) : (cnt == CNT_W'(1));
      end
      default: ;
    endcase

    if (state_q == ST_PLO_D && cnt_zero && cmd_q.op == OP_RD) begin
      rdata_d = bus.p2i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      prog_n_q    <= 1'b1;
      p2_oe_q     <= 1'b0;
      p2o_q       <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      prog_n_q    <= prog_n_d;
      p2_oe_q     <= p2_oe_d;
      p2o_q       <= p2o_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  // Ready is gated by rst_n so it reads 0 throughout reset and 1 right after release.
  assign bus.cmd_ready = rst_n & (state_q == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.p2o       = p2o_q;
  assign bus.p2_oe     = p2_oe_q;
  assign bus.prog_n    = prog_n_q;

endmodule

// File: tb/tb_p2_exp_master.sv
// Randomized bench for p2_exp_master; expected bus waveforms come from phase
// boundaries computed from the timing parameters.
module tb_p2_exp_master;
  import p2_exp_pkg::*;

  localparam int unsigned T_AS = 2;
  localparam int unsigned T_AH = 2;
  localparam int unsigned T_PW = 6;
  localparam int unsigned T_DH = 2;
  localparam int PA = T_AS;
  localparam int PB = T_AS + T_AH;
  localparam int PC = PB + T_PW;
  localparam int PS = PC + T_DH;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  p2_exp_master_if bus ();

  p2_exp_master #(
    .T_AS  (T_AS),
    .T_AH  (T_AH),
    .T_PW  (T_PW),
    .T_DH  (T_DH),
    .CNT_W (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_chk    = 0;
  int         n_bad    = 0;
  int         last_acc = 0;
  logic [3:0] last_rd  = 4'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic scramble();
    bus.cmd_valid = 1'($urandom);
    bus.cmd_op    = 2'($urandom);
    bus.cmd_port  = 2'($urandom);
    bus.cmd_wdata = 4'($urandom);
  endtask

  // Entered mid-cycle with the DUT idle; returns mid-cycle in the idle cycle after rsp.
  task automatic run_txn(input logic [1:0] op, input logic [1:0] port, input logic [3:0] wd,
                         input logic [3:0] rd, input int gap, input bit b2b, input bit churn);
    logic [3:0] addr;
    bit         is_rd;
    bit         exp_prog;
    bit         exp_oe;
    logic [3:0] exp_p2o;
    addr  = {op, port};
    is_rd = (op == 2'b00);

    for (int g = 0; g < gap; g++) begin
      check("idle_ready", bus.cmd_ready, 1);
      check("idle_prog",  bus.prog_n, 1);
      check("idle_oe",    bus.p2_oe, 0);
      check("idle_rsp",   bus.rsp_valid, 0);
      scramble();
      bus.cmd_valid = 1'b0;
      bus.p2i       = 4'($urandom);
      @(negedge clk);
    end

    check("acc_ready", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_port  = port;
    bus.cmd_wdata = wd;
    bus.p2i       = 4'($urandom);
    if (b2b) check("b2b_period", 32'(cyc + 1 - last_acc), 32'(PS + 1));
    last_acc = cyc + 1;

    for (int k = 0; k < PS; k++) begin
      @(negedge clk);
      exp_prog = (k < PA) || (k >= PC);
      exp_oe   = is_rd ? (k < PB) : 1'b1;
      exp_p2o  = (k < PB) ? addr : wd;
      check("prog_n",     bus.prog_n, exp_prog);
      check("p2_oe",      bus.p2_oe, exp_oe);
      if (exp_oe) check("p2o", bus.p2o, exp_p2o);
      check("rsp_valid",  bus.rsp_valid, (k == PS - 1));
      check("busy_ready", bus.cmd_ready, 0);
      check("rsp_rdata",  bus.rsp_rdata, (is_rd && k >= PC) ? rd : last_rd);
      // Responder lags one cycle into the data phase, garbage elsewhere.
      bus.p2i = (is_rd && k >= PB + 1 && k < PC) ? rd : 4'($urandom);
      if (churn) scramble();
    end
    if (is_rd) last_rd = rd;
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] r_op;
    logic [1:0] r_port;
    logic [3:0] r_wd;
    logic [3:0] r_rd;
    int         r_gap;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_port  = 2'b00;
    bus.cmd_wdata = 4'h0;
    bus.p2i       = 4'h0;
    rst_n         = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_prog",  bus.prog_n, 1);
    check("rst_oe",    bus.p2_oe, 0);
    check("rst_p2o",   bus.p2o, 0);
    check("rst_ready", bus.cmd_ready, 0);
    check("rst_rsp",   bus.rsp_valid, 0);
    check("rst_rdata", bus.rsp_rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(2'b01, PORT4, 4'hA, 4'h0, 0, 1'b0, 1'b0);
    run_txn(2'b00, PORT5, 4'h0, 4'h3, 1, 1'b0, 1'b0);
    run_txn(2'b10, PORT7, 4'h5, 4'h0, 2, 1'b0, 1'b0);
    run_txn(2'b11, PORT6, 4'hC, 4'h0, 0, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      r_op   = 2'($urandom);
      r_port = 2'($urandom);
      r_wd   = 4'($urandom);
      r_rd   = 4'($urandom);
      r_gap  = int'($urandom_range(0, 2));
      run_txn(r_op, r_port, r_wd, r_rd, r_gap, (r_gap == 0), 1'b1);
    end

    // Reset dropped into the data phase of a write.
    check("mr_ready", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b01;
    bus.cmd_port  = PORT6;
    bus.cmd_wdata = 4'h9;
    repeat (PB + 3) @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("mr_pre_prog", bus.prog_n, 0);
    check("mr_pre_p2o",  bus.p2o, 4'h9);
    #2 rst_n = 1'b0;
    #1;
    check("mr_prog",  bus.prog_n, 1);
    check("mr_oe",    bus.p2_oe, 0);
    check("mr_ready", bus.cmd_ready, 0);
    check("mr_rsp",   bus.rsp_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mr_hold_rsp",  bus.rsp_valid, 0);
      check("mr_hold_prog", bus.prog_n, 1);
      check("mr_hold_oe",   bus.p2_oe, 0);
    end
    rst_n   = 1'b1;
    last_rd = 4'h0;
    #1;
    check("mr_rel_ready", bus.cmd_ready, 1);
    check("mr_rel_rsp",   bus.rsp_valid, 0);
    run_txn(2'b00, PORT5, 4'h0, 4'h6, 0, 1'b0, 1'b0);
    run_txn(2'b01, PORT7, 4'h2, 4'h0, 0, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
